// File: rtl/fpu_add_sub_scheduler_pkg.sv
// Shared types for the FP add/sub scheduler: requester ID encoding and the
// per-stage tag carried alongside operations inside the shared FPU.
package fpu_sched_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REQ_MAX    = 8;

  typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fpu_add_sub_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr_i+1 (wrapping) and grants the
// first pending request. The pointer itself is owned by the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IdW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic [IdW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdW-1:0]     idx_o,
  output logic               valid_o
);

  int           sum;
  logic         found;
  logic [IdW-1:0] cand;

  always_comb begin
    sum     = 0;
    found   = 1'b0;
    cand    = '0;
    idx_o   = '0;
    grant_o = '0;
    // k == NUM_REQ wraps back to the pointer itself, so it is checked last
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IdW'(sum);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    valid_o = found & en_i;
    if (valid_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fpu_add_sub_scheduler.sv
// Shares one fixed-latency pipelined FP32 add/sub unit between NUM_REQ
// requesters; a tag pipeline matching the FPU latency routes results back.
module fpu_add_sub_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FPU_LATENCY = 3
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_REQ-1:0]                   i_req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_b,
  input  logic [NUM_REQ-1:0]                   i_req_sub,
  output logic [NUM_REQ-1:0]                   o_req_ready,
  input  logic                                 i_hold,
  output logic                                 o_fpu_valid,
  output logic [DATA_WIDTH-1:0]                o_fpu_a,
  output logic [DATA_WIDTH-1:0]                o_fpu_b,
  output logic                                 o_fpu_sub,
  input  logic [DATA_WIDTH-1:0]                i_fpu_result,
  output logic [NUM_REQ-1:0]                   o_res_valid,
  output logic [DATA_WIDTH-1:0]                o_res_data,
  output logic [$clog2(FPU_LATENCY+2)-1:0]     o_inflight,
  output logic                                 o_idle
);

  localparam int IdW  = $clog2(NUM_REQ);
  localparam int CntW = $clog2(FPU_LATENCY + 2);

  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]        win_idx;
  logic                  handshake;
  logic                  arb_en;

  logic                  fpu_valid_q, fpu_valid_d;
  logic [DATA_WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [DATA_WIDTH-1:0] fpu_b_q, fpu_b_d;
  logic                  fpu_sub_q, fpu_sub_d;
  req_id_t               issue_id_q, issue_id_d;

  tag_t                  tag_q [FPU_LATENCY];
  tag_t                  tag_d [FPU_LATENCY];
  tag_t                  tag_last;
  logic                  retire;

  logic [CntW-1:0]       inflight_q, inflight_d;

  // Ready is gated by reset too, so no grant is offered while i_rst_n is low
  assign arb_en = ~i_hold & i_rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (i_req_valid),
    .en_i    (arb_en),
    .ptr_i   (rr_ptr_q),
    .grant_o (o_req_ready),
    .idx_o   (win_idx),
    .valid_o (handshake)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    fpu_valid_d = handshake;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_sub_d   = fpu_sub_q;
    issue_id_d  = issue_id_q;
    if (handshake) begin
      rr_ptr_d   = win_idx;
      fpu_a_d    = i_req_a[win_idx];
      fpu_b_d    = i_req_b[win_idx];
      fpu_sub_d  = i_req_sub[win_idx];
      issue_id_d = req_id_t'(win_idx);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q    <= IdW'(NUM_REQ - 1);
      fpu_valid_q <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_sub_q   <= 1'b0;
      issue_id_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      fpu_valid_q <= fpu_valid_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_sub_q   <= fpu_sub_d;
      issue_id_q  <= issue_id_d;
    end
  end

  // Tags trail the issue register by one stage per cycle, never stalling,
  // so the final stage lines up with i_fpu_result.
  always_comb begin
    tag_d[0] = '{valid: fpu_valid_q, id: issue_id_q};
    for (int i = 1; i < FPU_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FPU_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FPU_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign tag_last = tag_q[FPU_LATENCY-1];
  assign retire   = tag_last.valid;

  always_comb begin
    o_res_valid = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      o_res_valid[p] = retire && (tag_last.id == req_id_t'(p));
    end
  end

  assign o_res_data = i_fpu_result;

  always_comb begin
    inflight_d = inflight_q;
    case ({handshake, retire})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign o_fpu_valid = fpu_valid_q;
  assign o_fpu_a     = fpu_a_q;
  assign o_fpu_b     = fpu_b_q;
  assign o_fpu_sub   = fpu_sub_q;
  assign o_inflight  = inflight_q;
  assign o_idle      = (inflight_q == '0) & ~fpu_valid_q & ~(|i_req_valid);

endmodule

// File: tb/tb_fpu_add_sub_scheduler.sv
// Directed bench for fpu_add_sub_scheduler: a cycle table for contention,
// hold and sparse arbitration, plus hand sequences for the multi-cycle cases.
module tb_fpu_add_sub_scheduler;

  localparam int NumReq = 4;
  localparam int Dw     = 32;
  localparam int Lat    = 3;
  localparam int NumVec = 28;

  logic                         clk;
  logic                         rstN;
  logic [NumReq-1:0]            reqValid;
  logic [NumReq-1:0][Dw-1:0]    reqA;
  logic [NumReq-1:0][Dw-1:0]    reqB;
  logic [NumReq-1:0]            reqSub;
  logic [NumReq-1:0]            reqReady;
  logic                         holdIn;
  logic                         fpuValid;
  logic [Dw-1:0]                fpuA;
  logic [Dw-1:0]                fpuB;
  logic                         fpuSub;
  logic [Dw-1:0]                fpuResult;
  logic [NumReq-1:0]            resValid;
  logic [Dw-1:0]                resData;
  logic [$clog2(Lat+2)-1:0]     inflight;
  logic                         idle;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [3:0] valid;
    logic       hold;
    logic [3:0] expReady;
    logic       expFpuValid;
    logic [3:0] expRes;
    logic [2:0] expInflight;
    logic       expIdle;
  } vec_t;

  vec_t        vecs [NumVec];
  logic [31:0] tabA [NumReq];
  logic [31:0] tabB [NumReq];
  logic        tabSub [NumReq];

  fpu_add_sub_scheduler #(
    .NUM_REQ     (NumReq),
    .DATA_WIDTH  (Dw),
    .FPU_LATENCY (Lat)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_req_valid  (reqValid),
    .i_req_a      (reqA),
    .i_req_b      (reqB),
    .i_req_sub    (reqSub),
    .o_req_ready  (reqReady),
    .i_hold       (holdIn),
    .o_fpu_valid  (fpuValid),
    .o_fpu_a      (fpuA),
    .o_fpu_b      (fpuB),
    .o_fpu_sub    (fpuSub),
    .i_fpu_result (fpuResult),
    .o_res_valid  (resValid),
    .o_res_data   (resData),
    .o_inflight   (inflight),
    .o_idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in FPU: exact results for the known FP test cases, a scrambled
  // operand signature otherwise so routing errors still show up in the data.
  function automatic logic [31:0] fpuModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
    if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return 32'h40400000;
    if (a == 32'h40A00000 && b == 32'h3F800000 && sub)  return 32'h40800000;
    if (a == 32'h3F800000 && b == 32'h3F800000 && !sub) return 32'h40000000;
    return a ^ {b[15:0], b[31:16]} ^ {31'd0, sub};
  endfunction

  logic [31:0] pipeData [Lat];
  always @(posedge clk) begin
    pipeData[0] <= fpuModel(fpuA, fpuB, fpuSub);
    for (int i = 1; i < Lat; i++) pipeData[i] <= pipeData[i-1];
  end
  assign fpuResult = pipeData[Lat-1];

  function automatic int onehotIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic h);
    reqValid = valid;
    holdIn   = h;
  endtask

  task automatic setTableOperands();
    for (int p = 0; p < NumReq; p++) begin
      tabA[p]   = 32'h1000_0123 + 32'h1000_0000 * p;
      tabB[p]   = 32'h00AB_0000 + p;
      tabSub[p] = p[0];
      reqA[p]   = tabA[p];
      reqB[p]   = tabB[p];
      reqSub[p] = tabSub[p];
    end
  endtask

  initial begin
    //         valid  hold ready fpuV res  infl idle
    vecs[0]  = '{4'hF, 0, 4'h1, 1, 4'h0, 3'd1, 0};
    vecs[1]  = '{4'hF, 0, 4'h2, 1, 4'h0, 3'd2, 0};
    vecs[2]  = '{4'hF, 0, 4'h4, 1, 4'h0, 3'd3, 0};
    vecs[3]  = '{4'hF, 0, 4'h8, 1, 4'h1, 3'd4, 0};
    vecs[4]  = '{4'hF, 0, 4'h1, 1, 4'h2, 3'd4, 0};
    vecs[5]  = '{4'hF, 0, 4'h2, 1, 4'h4, 3'd4, 0};
    vecs[6]  = '{4'hF, 0, 4'h4, 1, 4'h8, 3'd4, 0};
    vecs[7]  = '{4'hF, 0, 4'h8, 1, 4'h1, 3'd4, 0};
    vecs[8]  = '{4'h0, 0, 4'h0, 0, 4'h2, 3'd3, 0};
    vecs[9]  = '{4'h0, 0, 4'h0, 0, 4'h4, 3'd2, 0};
    vecs[10] = '{4'h0, 0, 4'h0, 0, 4'h8, 3'd1, 0};
    vecs[11] = '{4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 1};
    vecs[12] = '{4'hF, 0, 4'h1, 1, 4'h0, 3'd1, 0};
    vecs[13] = '{4'hF, 1, 4'h0, 0, 4'h0, 3'd1, 0};
    vecs[14] = '{4'hF, 1, 4'h0, 0, 4'h0, 3'd1, 0};
    vecs[15] = '{4'hF, 1, 4'h0, 0, 4'h1, 3'd1, 0};
    vecs[16] = '{4'hF, 0, 4'h2, 1, 4'h0, 3'd1, 0};
    vecs[17] = '{4'h0, 0, 4'h0, 0, 4'h0, 3'd1, 0};
    vecs[18] = '{4'h0, 0, 4'h0, 0, 4'h0, 3'd1, 0};
    vecs[19] = '{4'h0, 0, 4'h0, 0, 4'h2, 3'd1, 0};
    vecs[20] = '{4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 1};
    vecs[21] = '{4'h5, 0, 4'h4, 1, 4'h0, 3'd1, 0};
    vecs[22] = '{4'h9, 0, 4'h8, 1, 4'h0, 3'd2, 0};
    vecs[23] = '{4'h3, 0, 4'h1, 1, 4'h0, 3'd3, 0};
    vecs[24] = '{4'h0, 0, 4'h0, 0, 4'h4, 3'd3, 0};
    vecs[25] = '{4'h0, 0, 4'h0, 0, 4'h8, 3'd2, 0};
    vecs[26] = '{4'h0, 0, 4'h0, 0, 4'h1, 3'd1, 0};
    vecs[27] = '{4'h0, 0, 4'h0, 0, 4'h0, 3'd0, 1};

    setTableOperands();
    rstN = 1'b1;
    applyStimulus(4'hF, 1'b0);
    #2 rstN = 1'b0;

    // Reset state, with requests pending to show ready is gated
    @(negedge clk);
    checkOutput("rst ready", 32'(reqReady), 32'h0);
    checkOutput("rst fpu_valid", 32'(fpuValid), 32'h0);
    checkOutput("rst fpu_a", fpuA, 32'h0);
    checkOutput("rst fpu_b", fpuB, 32'h0);
    checkOutput("rst fpu_sub", 32'(fpuSub), 32'h0);
    checkOutput("rst res_valid", 32'(resValid), 32'h0);
    checkOutput("rst inflight", 32'(inflight), 32'h0);
    checkOutput("rst idle", 32'(idle), 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Contention, hold, sparse arbitration and idle
    for (int i = 0; i < NumVec; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].hold);
      #1 checkOutput($sformatf("row%0d ready", i), 32'(reqReady), 32'(vecs[i].expReady));
      @(negedge clk);
      checkOutput($sformatf("row%0d fpu_valid", i), 32'(fpuValid), 32'(vecs[i].expFpuValid));
      checkOutput($sformatf("row%0d res_valid", i), 32'(resValid), 32'(vecs[i].expRes));
      checkOutput($sformatf("row%0d inflight", i), 32'(inflight), 32'(vecs[i].expInflight));
      checkOutput($sformatf("row%0d idle", i), 32'(idle), 32'(vecs[i].expIdle));
      if (vecs[i].expRes != 4'h0) begin
        checkOutput($sformatf("row%0d res_data", i), resData,
                    fpuModel(tabA[onehotIdx(vecs[i].expRes)], tabB[onehotIdx(vecs[i].expRes)],
                             tabSub[onehotIdx(vecs[i].expRes)]));
      end
    end

    // Single op from requester 2: 1.0 + 2.0
    reqA[2] = 32'h3F800000; reqB[2] = 32'h40000000; reqSub[2] = 1'b0;
    applyStimulus(4'h4, 1'b0);
    #1 checkOutput("single ready", 32'(reqReady), 32'h4);
    @(negedge clk);
    applyStimulus(4'h0, 1'b0);
    checkOutput("single fpu_valid", 32'(fpuValid), 32'h1);
    checkOutput("single fpu_a", fpuA, 32'h3F800000);
    checkOutput("single fpu_b", fpuB, 32'h40000000);
    checkOutput("single fpu_sub", 32'(fpuSub), 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("single early res", 32'(resValid), 32'h0);
    end
    @(negedge clk);
    checkOutput("single res_valid", 32'(resValid), 32'h4);
    checkOutput("single res_data", resData, 32'h40400000);

    // Requester 1: 5.0 - 1.0, then requester 3: 1.0 + 1.0
    reqA[1] = 32'h40A00000; reqB[1] = 32'h3F800000; reqSub[1] = 1'b1;
    reqA[3] = 32'h3F800000; reqB[3] = 32'h3F800000; reqSub[3] = 1'b0;
    applyStimulus(4'h2, 1'b0);
    #1 checkOutput("sub ready p1", 32'(reqReady), 32'h2);
    @(negedge clk);
    checkOutput("sub fpu_sub", 32'(fpuSub), 32'h1);
    applyStimulus(4'h8, 1'b0);
    #1 checkOutput("sub ready p3", 32'(reqReady), 32'h8);
    @(negedge clk);
    applyStimulus(4'h0, 1'b0);
    checkOutput("add fpu_sub", 32'(fpuSub), 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("sub res_valid p1", 32'(resValid), 32'h2);
    checkOutput("sub res_data p1", resData, 32'h40800000);
    @(negedge clk);
    checkOutput("add res_valid p3", 32'(resValid), 32'h8);
    checkOutput("add res_data p3", resData, 32'h40000000);
    checkOutput("drain idle early", 32'(idle), 32'h0);
    @(negedge clk);
    checkOutput("drain inflight", 32'(inflight), 32'h0);
    checkOutput("drain idle", 32'(idle), 32'h1);

    // Reset with three operations in flight
    setTableOperands();
    applyStimulus(4'hF, 1'b0);
    #1 checkOutput("mid ready 0", 32'(reqReady), 32'h1);
    @(negedge clk);
    #1 checkOutput("mid ready 1", 32'(reqReady), 32'h2);
    @(negedge clk);
    #1 checkOutput("mid ready 2", 32'(reqReady), 32'h4);
    @(negedge clk);
    checkOutput("mid inflight", 32'(inflight), 32'h3);
    rstN = 1'b0;
    #1;
    checkOutput("mid rst fpu_valid", 32'(fpuValid), 32'h0);
    checkOutput("mid rst fpu_a", fpuA, 32'h0);
    checkOutput("mid rst fpu_b", fpuB, 32'h0);
    checkOutput("mid rst inflight", 32'(inflight), 32'h0);
    checkOutput("mid rst ready", 32'(reqReady), 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("mid rst res_valid", 32'(resValid), 32'h0);
    end
    applyStimulus(4'h0, 1'b0);
    rstN = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post rst res_valid", 32'(resValid), 32'h0);
      checkOutput("post rst inflight", 32'(inflight), 32'h0);
    end
    applyStimulus(4'hF, 1'b0);
    #1 checkOutput("post rst first grant", 32'(reqReady), 32'h1);
    @(negedge clk);
    applyStimulus(4'h0, 1'b0);
    checkOutput("post rst fpu_a", fpuA, tabA[0]);
    repeat (Lat + 2) @(negedge clk);
    checkOutput("final idle", 32'(idle), 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fpu_add_sub_scheduler.md
# fpu_add_sub_scheduler

Shares one fixed-latency pipelined FP32 add/sub unit (FPU_ADD_SUB) between `NUM_REQ` requesters, such as the FFT butterfly lanes. Each cycle it runs a round-robin arbitration over the pending requests and issues at most one operation to the FPU. It carries each requester ID through a tag pipeline that matches the FPU latency, then returns each result to the requester that issued it. It sits between the butterfly datapath and the single shared FPU_ADD_SUB instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/result width (IEEE-754 single).
- FPU_LATENCY, 3, cycles from FPU input valid to FPU result valid (≥1).

Ports:
- i_clk  in  1  clock; everything is rising-edge.
- i_rst_n  in  1  reset: asynchronous assert, active-low.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_a  in  NUM_REQ×DATA_WIDTH  operand A per requester.
- i_req_b  in  NUM_REQ×DATA_WIDTH  operand B per requester.
- i_req_sub  in  NUM_REQ  1 = A−B, 0 = A+B.
- o_req_ready  out  NUM_REQ  one-hot or zero grant; the handshake completes when valid&ready.
- i_hold  in  1  1 = issue no new operation this cycle; in-flight operations still complete.
- o_fpu_valid  out  1  issue strobe to the FPU.
- o_fpu_a, o_fpu_b  out  DATA_WIDTH  registered operands to the FPU.
- o_fpu_sub  out  1  registered operation select.
- i_fpu_result  in  DATA_WIDTH  FPU result, valid exactly FPU_LATENCY cycles after o_fpu_valid.
- o_res_valid  out  NUM_REQ  one-hot result strobe to the owning requester.
- o_res_data  out  DATA_WIDTH  result, broadcast to all requesters.
- o_inflight  out  $clog2(FPU_LATENCY+2)  number of operations issued but not yet returned.
- o_idle  out  1  1 when o_inflight==0, o_fpu_valid==0 and no i_req_valid bit is set.

## Operation
- Arbitration:
  - Round-robin priority pointer `rr_ptr`.
  - The search starts at rr_ptr+1 (mod NUM_REQ); the first set i_req_valid bit wins.
  - o_req_ready is combinational: the winner's bit, gated by ~i_hold.
  - On a handshake, rr_ptr ← winner index.
  - Without a handshake, rr_ptr holds.
- Issue register:
  - On a handshake, o_fpu_a/b/sub ← the winner's operands and o_fpu_valid ← 1.
  - Otherwise o_fpu_valid ← 0 and the operand registers hold.
- Tag pipeline: FPU_LATENCY stages, each holding {valid, req_id}. Stage 0 loads {o_fpu_valid, id of the issued operation}; each stage shifts one per cycle and never stalls.
- Return path: when the final stage is valid, o_res_valid = onehot(req_id) and o_res_data = i_fpu_result. Otherwise o_res_valid = 0 and o_res_data is don't-care (drive i_fpu_result).
- Requesters have no result backpressure: a result strobe must be consumed in that cycle.
- In-flight counter:
  - +1 on a handshake.
  - −1 when the final tag stage is valid.
  - Both in the same cycle: the value is unchanged.
  - Maximum is FPU_LATENCY+1. The counter saturates by construction and never wraps.
- Operand ordering: results return in issue order. A requester can have several operations outstanding at once.

## Timing
- Reset (async, while i_rst_n==0):
  - o_fpu_valid=0, o_fpu_a=o_fpu_b=0, o_fpu_sub=0.
  - All tag stages invalid, so o_res_valid=0.
  - o_inflight=0.
  - rr_ptr=NUM_REQ−1, so requester 0 has top priority after reset.
  - o_req_ready is 0 while in reset.
- Latency: a handshake at edge t gives o_fpu_valid high during cycle t+1 and o_res_valid high during cycle t+1+FPU_LATENCY. The total is FPU_LATENCY+1 cycles.
- Throughput: one issue per cycle when requests are continuously pending. With all ports valid, the grants rotate 0,1,2,3,0,…
- i_hold:
  - Asserted: o_req_ready=0 for that cycle, and no rr_ptr change.
  - The tag pipeline keeps draining.
- Reset mid-operation: all in-flight operations are discarded with no result strobe. The FPU's internal pipeline contents are ignored because the tags are invalid.
- A requester dropping i_req_valid without a handshake is legal. The arbiter simply re-evaluates.

## Structure
- Package `fpu_sched_pkg`:
  - DATA_WIDTH default constant.
  - typedef `req_id_t` = logic [$clog2(NUM_REQ_MAX)-1:0] with NUM_REQ_MAX=8.
  - typedef struct `tag_t` {logic valid; req_id_t id;}.
- Sub-module `rr_arbiter`:
  - Parameterised by NUM_REQ.
  - Inputs: request vector, enable, pointer.
  - Outputs: one-hot grant and encoded index.
  - Pointer update stays in the parent.
- The FPU itself is instantiated outside this block.

## Test plan
- Single op: FPU_LATENCY=3. Requester 2 sends A=0x3F800000, B=0x40000000, sub=0 at edge 0 → o_fpu_valid in cycle 1; o_res_valid=4'b0100 in cycle 4 with o_res_data=0x40400000 (FPU model).
- Full contention: all 4 valid for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3; o_res_valid follows the same order 4 cycles after each grant; o_inflight peaks at 4.
- Subtract and mixed ownership: requester 1 sends 0x40A00000−0x3F800000, then requester 3 sends 1.0+1.0 → results 0x40800000 to port 1, then 0x40000000 to port 3, in order.
- Hold: i_hold=1 for 3 cycles with requests pending → no ready, no o_fpu_valid; in-flight ops still return; rr_ptr is unchanged, so the next grant resumes at the expected port.
- Reset mid-flight: assert i_rst_n=0 with o_inflight=3 → all outputs clear asynchronously, no o_res_valid after release, and the first grant goes to requester 0.
- Idle: no requests after draining → o_idle=1 exactly when o_inflight reaches 0 and o_fpu_valid=0.
